// File: rtl/ps2_arrow_tx_if.sv
// Key levels, host inhibit and PS/2 line/status signals of the arrow-key transmitter.
// master = key/host side driving the keys, slave = the transmitter itself.
interface ps2_arrow_tx_if;
    logic left;
    logic down;
    logic right;
    logic up;
    logic inhibit;
    logic ps2_clk;
    logic ps2_data;
    logic busy;
    logic seq_done;

    modport master (
        output left, down, right, up, inhibit,
        input  ps2_clk, ps2_data, busy, seq_done
    );

    modport slave (
        input  left, down, right, up, inhibit,
        output ps2_clk, ps2_data, busy, seq_done
    );
endinterface

// File: rtl/ps2_arrow_tx.sv
// PS/2 device-side transmitter: turns arrow-key level changes into set-2 extended
// make (E0 xx) / break (E0 F0 xx) frames on ps2_clk/ps2_data.
//
// state    | meaning
// IDLE     | lines high, waiting for a key that differs from what was reported
// START    | start bit (0) on the line
// DATA     | data bits 0..7, LSB first
// PARITY   | odd parity bit
// STOP     | stop bit (1)
// GAP      | inter-byte idle, GAP_DIV cycles
// GAP_WAIT | gap over, more bytes pending, host is inhibiting
module ps2_arrow_tx #(
    parameter int HALF_DIV = 2500,
    parameter int GAP_DIV  = 5000
) (
    input logic          clk,
    input logic          rst_n,
    ps2_arrow_tx_if.slave bus
);

    localparam int HW = $clog2(HALF_DIV);
    localparam int GW = (GAP_DIV > 1) ? $clog2(GAP_DIV) : 1;
    localparam logic [HW-1:0] HALF_LAST = HW'(HALF_DIV - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_DIV - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, GAP, GAP_WAIT} state_t;

    state_t        state;
    logic [3:0]    reported;
    logic [1:0]    key_sel;
    logic          make;
    logic [1:0]    byte_idx;
    logic [3:0]    bit_idx;
    logic [HW-1:0] half_cnt;
    logic [GW-1:0] gap_cnt;
    logic          clk_q, data_q, busy_q, done_q;

    logic [3:0] keys, diff;
    logic [1:0] pick;
    logic [7:0] code, cur_byte;
    logic       last_byte;
    logic [3:0] nxt_idx;
    logic       nxt_bit;

    assign keys = {bus.up, bus.right, bus.down, bus.left};
    assign diff = keys ^ reported;

    assign bus.ps2_clk  = clk_q;
    assign bus.ps2_data = data_q;
    assign bus.busy     = busy_q;
    assign bus.seq_done = done_q;

    // Lowest index wins when several keys changed.
    always_comb begin
        pick = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (diff[i]) pick = 2'(i);
        end
    end

    always_comb begin
        case (key_sel)
            2'd0:    code = 8'h6B;
            2'd1:    code = 8'h72;
            2'd2:    code = 8'h74;
            default: code = 8'h75;
        endcase
        cur_byte = 8'hE0;
        if (byte_idx == 2'd1) cur_byte = make ? code : 8'hF0;
        if (byte_idx == 2'd2) cur_byte = code;
        last_byte = make ? (byte_idx == 2'd1) : (byte_idx == 2'd2);
        nxt_idx = bit_idx + 4'd1;
        case (nxt_idx)
            4'd9:    nxt_bit = ~^cur_byte;
            4'd10:   nxt_bit = 1'b1;
            default: nxt_bit = cur_byte[3'(nxt_idx - 4'd1)];
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            reported <= 4'b0000;
            key_sel  <= 2'd0;
            make     <= 1'b0;
            byte_idx <= 2'd0;
            bit_idx  <= 4'd0;
            half_cnt <= '0;
            gap_cnt  <= '0;
            clk_q    <= 1'b1;
            data_q   <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (diff != 4'b0000 && !bus.inhibit) begin
                        key_sel  <= pick;
                        make     <= keys[pick];
                        byte_idx <= 2'd0;
                        bit_idx  <= 4'd0;
                        half_cnt <= '0;
                        data_q   <= 1'b0;
                        busy_q   <= 1'b1;
                        state    <= START;
                    end
                end
                START, DATA, PARITY, STOP: begin
                    if (half_cnt == HALF_LAST) begin
                        half_cnt <= '0;
                        if (clk_q) begin
                            clk_q <= 1'b0;
                        end else begin
                            // Rising ps2_clk is the only moment the data line may move.
                            clk_q <= 1'b1;
                            if (state == STOP) begin
                                bit_idx <= 4'd0;
                                data_q  <= 1'b1;
                                gap_cnt <= '0;
                                state   <= GAP;
                            end else begin
                                bit_idx <= nxt_idx;
                                data_q  <= nxt_bit;
                                state   <= (nxt_idx == 4'd9)  ? PARITY :
                                           (nxt_idx == 4'd10) ? STOP : DATA;
                            end
                        end
                    end else begin
                        half_cnt <= half_cnt + 1'b1;
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        gap_cnt <= '0;
                        if (last_byte) begin
                            reported[key_sel] <= make;
                            byte_idx          <= 2'd0;
                            done_q            <= 1'b1;
                            busy_q            <= 1'b0;
                            state             <= IDLE;
                        end else begin
                            byte_idx <= byte_idx + 2'd1;
                            if (!bus.inhibit) begin
                                data_q <= 1'b0;
                                state  <= START;
                            end else begin
                                state <= GAP_WAIT;
                            end
                        end
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                GAP_WAIT: begin
                    if (!bus.inhibit) begin
                        half_cnt <= '0;
                        data_q   <= 1'b0;
                        state    <= START;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
